// File: rtl/led_frame_scheduler.sv
`timescale 1ns/1ps
// Frame scheduler for the 6-LED/144-bit PWM driver: buffers GRB pixels, streams 144-bit chunks, then latches.
// Optional auto-refresh is built only when LED_AUTO_REFRESH_EN is defined.
module led_frame_scheduler #(
    parameter int NUM_CHUNKS     = 4,
    parameter int RESET_CYCLES   = 1500,
    parameter int TIMEOUT_CYCLES = 8192
`ifdef LED_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 2400000
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [$clog2(NUM_CHUNKS*6)-1:0] wr_addr,
    input  logic [23:0]                     wr_data,
    output logic                            wr_ready,
    input  logic                            frame_req,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            timeout_err,
    output logic                            drv_rst,
    output logic [143:0]                    drv_rgb,
    output logic                            drv_load,
    output logic                            drv_rst_leds,
    input  logic                            drv_done
);

    localparam int NUM_PIX = NUM_CHUNKS * 6;
    localparam int AW      = $clog2(NUM_PIX);
    localparam int CW      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CNT_MAX = ((TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES) - 1;
    localparam int CNTW    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNTW-1:0] TO_LAST    = CNTW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNTW-1:0] RST_LAST   = CNTW'(RESET_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_SAT    = CNTW'(CNT_MAX);
    localparam logic [CW-1:0]   LAST_CHUNK = CW'(NUM_CHUNKS - 1);
    localparam logic [AW:0]     NUM_PIX_W  = (AW + 1)'(NUM_PIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_SEND,
        S_ADV,
        S_LATCH,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [23:0]     r_buf [NUM_PIX];
    logic [CW-1:0]   r_chunk_idx;
    logic [CW-1:0]   w_sel_idx;
    logic [143:0]    r_drv_rgb;
    logic [143:0]    w_chunk;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_pix_idx;
    logic [CNTW-1:0] r_cnt;
    logic            r_pending;
    logic            r_timeout_err;
    logic            w_req;
    logic            w_wr_ok;
    logic            w_last_chunk;
    logic            w_timeout_hit;
    logic            w_latch_hit;

`ifdef LED_AUTO_REFRESH_EN
    localparam int             RW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] r_ref_cnt;
    logic          w_ref_req;

    assign w_ref_req = (r_state == S_IDLE) && (r_ref_cnt == REF_LAST);

    // Idle-time counter; restarts on every frame so refresh period is measured from IDLE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_cnt <= '0;
        end else if (w_state_next == S_PREP) begin
            r_ref_cnt <= '0;
        end else if (r_state == S_IDLE && r_ref_cnt != REF_LAST) begin
            r_ref_cnt <= r_ref_cnt + RW'(1);
        end
    end

    assign w_req = frame_req | w_ref_req;
`else
    assign w_req = frame_req;
`endif

    assign w_wr_ok       = (r_state == S_IDLE) && wr_en && ({1'b0, wr_addr} < NUM_PIX_W);
    assign w_last_chunk  = (r_chunk_idx == LAST_CHUNK);
    assign w_timeout_hit = (r_cnt == TO_LAST);
    assign w_latch_hit   = (r_cnt == RST_LAST);

    // NOTE: the pixel buffer carries an async reset so a frame sent right after reset is black;
    // that keeps it in flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '{default: '0};
        end else if (w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no branch leaves w_state_next unassigned and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_state_next = S_PREP;
            S_PREP:  w_state_next = S_SEND;
            S_SEND: begin
                if (drv_done) begin
                    w_state_next = S_ADV;
                end else if (w_timeout_hit) begin
                    w_state_next = S_LATCH;
                end
            end
            S_ADV:   w_state_next = w_last_chunk ? S_LATCH : S_SEND;
            S_LATCH: if (w_latch_hit) w_state_next = S_FIN;
            S_FIN:   w_state_next = (r_pending || w_req) ? S_PREP : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        wr_ready     = (r_state == S_IDLE);
        frame_done   = (r_state == S_FIN);
        drv_load     = (r_state == S_SEND);
        drv_rst_leds = !((r_state == S_SEND) || (r_state == S_ADV));
        drv_rst      = !rst || (r_state == S_PREP);
    end

    assign drv_rgb     = r_drv_rgb;
    assign timeout_err = r_timeout_err;

    // Shared timeout / latch counter: restarts on every state change and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == S_SEND || r_state == S_LATCH) && r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign w_sel_idx = (r_state == S_PREP) ? '0 : r_chunk_idx + CW'(1);
    assign w_base    = AW'(w_sel_idx) * AW'(6);

    // Pixel 0 of the chunk ends up in the top 24 bits after six shifts.
    always_comb begin
        w_chunk   = '0;
        w_pix_idx = '0;
        for (int k = 0; k < 6; k++) begin
            w_pix_idx = w_base + AW'(k);
            w_chunk   = {w_chunk[119:0],
                         ({1'b0, w_pix_idx} < NUM_PIX_W) ? r_buf[w_pix_idx] : 24'h0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chunk_idx <= '0;
            r_drv_rgb   <= '0;
        end else if (r_state == S_PREP) begin
            r_chunk_idx <= '0;
            r_drv_rgb   <= w_chunk;
        end else if (r_state == S_ADV && !w_last_chunk) begin
            r_chunk_idx <= r_chunk_idx + CW'(1);
            r_drv_rgb   <= w_chunk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == S_PREP) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == S_SEND && !drv_done && w_timeout_hit) begin
            r_timeout_err <= 1'b1;
        end
    end

    // Single-depth request memory; FIN consumes it (and any request arriving in FIN itself).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else if (r_state == S_FIN) begin
            r_pending <= 1'b0;
        end else if (r_state != S_IDLE && w_req) begin
            r_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
`timescale 1ns/1ps
// Directed bench for led_frame_scheduler: table-driven buffer writes plus hand-written frame sequences.
module tb_led_frame_scheduler;

    localparam int NUM_CHUNKS = 4;
    localparam int NUM_PIX    = 24;

    typedef struct {
        logic [4:0]  addr;
        logic [23:0] data;
        bit          accept;
    } wr_vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [23:0]  wr_data = '0;
    logic         frame_req = 1'b0;
    logic         drv_done_m = 1'b0;
    logic         drv_done_man = 1'b0;
    logic         drv_done;
    logic         wr_ready, busy, frame_done, timeout_err;
    logic         drv_rst, drv_load, drv_rst_leds;
    logic [143:0] drv_rgb;

    assign drv_done = drv_done_m | drv_done_man;

    always #5 clk = ~clk;

    led_frame_scheduler #(
        .NUM_CHUNKS     (NUM_CHUNKS),
        .RESET_CYCLES   (1500),
        .TIMEOUT_CYCLES (8192)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .frame_req    (frame_req),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .drv_rst      (drv_rst),
        .drv_rgb      (drv_rgb),
        .drv_load     (drv_load),
        .drv_rst_leds (drv_rst_leds),
        .drv_done     (drv_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0]  exp_buf [NUM_PIX];
    wr_vec_t      vecs [10];

    // Monitor / driver-model state
    int           mon_rises, gap_run, latch_run, latch_len, done_cnt;
    int           send_run, last_send_run, dcnt;
    bit           prev_load, model_en, tie_mode;
    logic [143:0] cap [8];
    int           gaps [8];

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] exp_chunk(input int c);
        logic [143:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r = {r[119:0], exp_buf[c * 6 + k]};
        return r;
    endfunction

    task automatic clear_mon();
        mon_rises = 0;
        gap_run   = 0;
        latch_run = 0;
        latch_len = -1;
        done_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            cap[i]  = '0;
            gaps[i] = -1;
        end
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, frame_done, 1'b1);
    endtask

    // Samples 2 ns after each rising edge; also plays the driver (done 40 cycles after load rises).
    always @(posedge clk) begin
        #2;
        drv_done_m = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) drv_done_m = 1'b1;
        end
        if (drv_load) begin
            send_run++;
        end else begin
            if (prev_load) last_send_run = send_run;
            send_run = 0;
        end
        if (tie_mode && drv_load && send_run == 8192) begin
            drv_done_m = 1'b1;
            tie_mode   = 1'b0;
            model_en   = 1'b1;
        end
        if (drv_load && !prev_load) begin
            if (mon_rises < 8) cap[mon_rises] = drv_rgb;
            if (mon_rises > 0 && mon_rises <= 8) gaps[mon_rises - 1] = gap_run;
            mon_rises++;
            if (model_en) dcnt = 39;
        end
        if (drv_load) gap_run = 0;
        else gap_run++;
        if (busy && drv_rst_leds && !frame_done) latch_run++;
        else if (!drv_rst_leds) latch_run = 0;
        if (frame_done) begin
            latch_len = latch_run;
            latch_run = 0;
            done_cnt++;
        end
        prev_load = drv_load;
    end

    initial begin
        int n;
        vecs[0] = '{5'd0,  24'hFF0000, 1'b1};
        vecs[1] = '{5'd24, 24'hDEADBE, 1'b0};
        vecs[2] = '{5'd5,  24'h0000FF, 1'b1};
        vecs[3] = '{5'd3,  24'h00FF00, 1'b1};
        vecs[4] = '{5'd6,  24'h111111, 1'b1};
        vecs[5] = '{5'd11, 24'h222222, 1'b1};
        vecs[6] = '{5'd12, 24'hABCDEF, 1'b1};
        vecs[7] = '{5'd23, 24'h0055AA, 1'b1};
        vecs[8] = '{5'd31, 24'h777777, 1'b0};
        vecs[9] = '{5'd18, 24'h00AA55, 1'b1};
        for (int i = 0; i < NUM_PIX; i++) exp_buf[i] = '0;
        clear_mon();
        model_en = 1'b1; tie_mode = 1'b0; dcnt = 0; send_run = 0; last_send_run = 0; prev_load = 1'b0;

        // Reset values while rst is held low
        repeat (3) @(negedge clk);
        check("rst_drv_rst", drv_rst, 1'b1);
        check("rst_drv_load", drv_load, 1'b0);
        check("rst_drv_rst_leds", drv_rst_leds, 1'b1);
        check("rst_drv_rgb", drv_rgb, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_drv_rst", drv_rst, 1'b0);
        check("idle_wr_ready", wr_ready, 1'b1);
        check("idle_leds", drv_rst_leds, 1'b1);

        // Buffer writes from the vector table
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
            check($sformatf("vec%0d_wr_ready", i), wr_ready, 1'b1);
            @(negedge clk);
            wr_en = 1'b0;
            if (vecs[i].accept) exp_buf[vecs[i].addr] = vecs[i].data;
        end

        // drv_done outside SEND is ignored
        drv_done_man = 1'b1;
        @(negedge clk);
        drv_done_man = 1'b0;
        @(negedge clk);
        check("stray_done_busy", busy, 1'b0);

        // Frame 1: latency, chunk contents, inter-chunk gap, latch length
        clear_mon();
        pulse_req();
        check("f1_busy_n1", busy, 1'b1);
        check("f1_load_n1", drv_load, 1'b0);
        @(negedge clk);
        check("f1_load_n2", drv_load, 1'b1);
        check("f1_pix0", drv_rgb[143:120], 24'hFF0000);
        check("f1_pix5", drv_rgb[23:0], 24'h0000FF);
        wait_frame_done("f1_done");
        check("f1_busy_at_fin", busy, 1'b1);
        check("f1_loads", mon_rises, NUM_CHUNKS);
        for (int c = 0; c < NUM_CHUNKS; c++) check($sformatf("f1_chunk%0d", c), cap[c], exp_chunk(c));
        for (int g = 0; g < NUM_CHUNKS - 1; g++) check($sformatf("f1_gap%0d", g), gaps[g], 1);
        check("f1_latch_len", latch_len, 1500);
        @(negedge clk);
        check("f1_busy_after", busy, 1'b0);
        check("f1_done_after", frame_done, 1'b0);
        repeat (10) @(negedge clk);
        check("f1_done_count", done_cnt, 1);

        // Merged pending requests and dropped write while busy
        clear_mon();
        pulse_req();
        n = 0;
        while (mon_rises < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("pend_reach_chunk1", mon_rises, 2);
        pulse_req();
        repeat (3) @(negedge clk);
        pulse_req();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 24'h123456;
        check("busy_wr_ready", wr_ready, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        wait_frame_done("pend_done_a");
        @(negedge clk);
        check("fin_to_prep_busy", busy, 1'b1);
        check("fin_to_prep_no_idle", wr_ready, 1'b0);
        clear_mon();
        wait_frame_done("pend_done_b");
        check("pend_loads", mon_rises, NUM_CHUNKS);
        check("pend_old_pixel3", cap[0], exp_chunk(0));
        repeat (20) @(negedge clk);
        check("pend_single_extra", busy, 1'b0);
        check("pend_done_count", done_cnt, 1);

        // Timeout: driver never answers
        model_en = 1'b0;
        clear_mon();
        pulse_req();
        n = 0;
        while (timeout_err !== 1'b1 && n < 9000) begin
            @(negedge clk);
            n++;
        end
        check("to_err_set", timeout_err, 1'b1);
        check("to_send_cycles", last_send_run, 8192);
        check("to_latch_leds", drv_rst_leds, 1'b1);
        wait_frame_done("to_done");
        check("to_err_at_fin", timeout_err, 1'b1);
        check("to_loads", mon_rises, 1);
        check("to_latch_len", latch_len, 1500);

        // Next frame clears the error; a write coinciding with frame_req is included
        model_en = 1'b1;
        @(negedge clk);
        clear_mon();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 24'hC0FFEE;
        frame_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; frame_req = 1'b0;
        exp_buf[7] = 24'hC0FFEE;
        @(negedge clk);
        check("err_cleared", timeout_err, 1'b0);
        wait_frame_done("coinc_done");
        check("coinc_write_chunk1", cap[1], exp_chunk(1));
        check("coinc_no_err", timeout_err, 1'b0);

        // drv_done on the timeout terminal cycle: done wins
        @(negedge clk);
        model_en = 1'b0; tie_mode = 1'b1;
        clear_mon();
        pulse_req();
        wait_frame_done("tie_done");
        check("tie_no_err", timeout_err, 1'b0);
        check("tie_loads", mon_rises, NUM_CHUNKS);
        check("tie_gap0", gaps[0], 1);
        model_en = 1'b1; tie_mode = 1'b0;

        // Asynchronous reset in the middle of SEND
        @(negedge clk);
        clear_mon();
        pulse_req();
        n = 0;
        while (drv_load !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ar_in_send", drv_load, 1'b1);
        repeat (5) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("ar_drv_load", drv_load, 1'b0);
        check("ar_drv_rst", drv_rst, 1'b1);
        check("ar_drv_rst_leds", drv_rst_leds, 1'b1);
        check("ar_busy", busy, 1'b0);
        check("ar_drv_rgb", drv_rgb, '0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NUM_PIX; i++) exp_buf[i] = '0;
        repeat (60) @(negedge clk);
        check("ar_no_frame_done", done_cnt, 0);
        clear_mon();
        pulse_req();
        wait_frame_done("ar_next_done");
        check("ar_buf_cleared", cap[0], exp_chunk(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Frame-level controller for the 6-LED/144-bit PWM LED driver.
- Holds a pixel buffer of NUM_CHUNKS*6 GRB words, written by the host (MCU/SPI side).
- On a frame request, feeds the driver one 144-bit chunk at a time, handshaking on the driver's done pulse.
- After the last chunk, holds the strip in its latch/reset interval, then reports frame completion.

Parameters:
- NUM_CHUNKS, 4, number of 6-LED chunks per frame (24 LEDs).
- RESET_CYCLES, 1500, clk cycles the line is held low after the last chunk (>50 us at 24 MHz).
- TIMEOUT_CYCLES, 8192, maximum clk cycles in SEND waiting for drv_done.
- REFRESH_CYCLES, 2400000, auto-refresh period in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  pixel write strobe
- wr_addr  in  $clog2(NUM_CHUNKS*6)  pixel index; 0 is sent first
- wr_data  in  24  pixel, {G[7:0],R[7:0],B[7:0]}
- wr_ready  out  1  buffer writable (high only in IDLE)
- frame_req  in  1  start-frame pulse
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame end
- timeout_err  out  1  sticky error flag: driver never returned done
- drv_rst  out  1  synchronous reset to the driver, active-high
- drv_rgb  out  144  chunk to the driver; pixel k of the chunk at [143-24k -: 24]
- drv_load  out  1  load/start to the driver
- drv_rst_leds  out  1  forces the driver output low
- drv_done  in  1  driver's chunk-complete pulse

Behaviour:
- Reset values (rst low, async): state IDLE; buffer all zero; drv_rst=1; drv_load=0; drv_rst_leds=1; drv_rgb=0; busy=0; frame_done=0; timeout_err=0; pending=0; chunk_idx=0.
- IDLE
  - drv_rst=0, drv_rst_leds=1, wr_ready=1; writes accepted.
  - frame_req → PREP.
  - A wr_en coinciding with frame_req is written first and is included in the frame.
- PREP (1 cycle)
  - busy=1, drv_rst=1, chunk_idx=0, timeout_err cleared.
  - drv_rgb is assembled from pixels 0..5 and registered. → SEND.
- SEND
  - drv_load=1, drv_rst_leds=0; timeout counter runs.
  - drv_done → ADV.
  - Counter reaching TIMEOUT_CYCLES-1 → timeout_err=1, → LATCH.
- ADV (1 cycle)
  - drv_load=0.
  - If chunk_idx==NUM_CHUNKS-1 → LATCH.
  - Otherwise chunk_idx+1, register the next chunk into drv_rgb, → SEND.
- LATCH
  - drv_rst_leds=1, drv_load=0; counts RESET_CYCLES.
  - At terminal count → FIN.
- FIN (1 cycle)
  - frame_done=1.
  - If pending is set: clear pending, → PREP.
  - Otherwise busy=0 next cycle, → IDLE.
- Latency: frame_req at cycle N gives busy=1 at N+1 and drv_load=1 at N+2 with drv_rgb stable.
- drv_rgb changes only in PREP/ADV and is stable throughout SEND.
- frame_req while busy sets pending (single-depth; further requests are merged).
- wr_en while busy: wr_ready=0, write dropped, buffer unchanged.
- wr_addr >= NUM_CHUNKS*6: write ignored.
- drv_done outside SEND: ignored.
- drv_done on the same cycle as the timeout terminal count: done wins, no error.
- Reset asserted mid-frame: immediate return to reset values. The driver is held in reset and the line is forced low. No frame_done is issued.
- Counters use the minimum width for their maximum value and saturate; they never wrap.

Optional Feature:
- Macro: LED_AUTO_REFRESH_EN.
- Defined:
  - A free-running refresh counter counts REFRESH_CYCLES while in IDLE.
  - At terminal count it raises an internal request identical to frame_req (retransmits the buffer).
  - The counter clears whenever PREP is entered.
  - A host frame_req on the same cycle as the refresh request starts only one frame.
- Undefined: frames start only on frame_req; the refresh logic is absent.

Test Plan:
- After reset, write pixel0=0xFF0000, pixel5=0x0000FF, pulse frame_req → drv_rgb[143:120]=0xFF0000 and [23:0]=0x0000FF at first drv_load. NUM_CHUNKS drv_load bursts follow, then drv_rst_leds high for exactly 1500 cycles, then one frame_done pulse.
- Driver model answers drv_done 40 cycles after each drv_load rise, NUM_CHUNKS=4 → drv_load drops for exactly one cycle between chunks; chunk_idx sequence 0,1,2,3; busy high from frame_req+1 until the cycle after frame_done.
- Pulse frame_req twice during SEND of chunk 1 → exactly one extra frame starts directly after FIN (FIN→PREP), with no IDLE cycle in between.
- Suppress drv_done → timeout_err=1 after 8192 SEND cycles, LATCH entered, frame_done still pulses; next frame_req clears timeout_err.
- wr_en to pixel 3 with 0x123456 while busy → wr_ready=0 and the next frame sends the old value; rst low mid-SEND → drv_load=0, drv_rst=1, drv_rst_leds=1 asynchronously.
- With LED_AUTO_REFRESH_EN and REFRESH_CYCLES=1000, idle with no frame_req → PREP entered 1000 cycles after entering IDLE, repeating every frame.
